// File: rtl/ghr_spec_ctrl.sv
// Global history register controller: speculative GHR shifted at prediction,
// architectural GHR shifted at in-order resolve, in-flight direction FIFO with recovery.
module ghr_spec_ctrl #(
    parameter int HISTORY_SIZE = 64,
    parameter int CKPT_DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              pred_valid,
    input  logic                              pred_taken,
    output logic                              pred_ready,
    input  logic                              resolve_valid,
    input  logic                              resolve_taken,
    input  logic                              flush,
    output logic [HISTORY_SIZE-1:0]           spec_history,
    output logic [HISTORY_SIZE-1:0]           arch_history,
    output logic                              mispredict,
    output logic                              recover_busy,
    output logic [$clog2(CKPT_DEPTH+1)-1:0]   inflight_count,
    output logic                              underflow_err
);

    localparam int PW = $clog2(CKPT_DEPTH);
    localparam int CW = $clog2(CKPT_DEPTH+1);

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    state_t                  state_q, state_nxt;
    logic [CKPT_DEPTH-1:0]   fifo_q;
    logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]           count_nxt;
    logic                    ready_nxt;

    logic                    accept, do_res, pop_bit, mis_nxt, kill, push;
    logic [HISTORY_SIZE-1:0] arch_nxt, spec_nxt;

    // Resolve and kill decode; the arch shift feeds the flush/mispredict restore.
    always_comb begin
        accept   = pred_valid && pred_ready;
        do_res   = resolve_valid && (inflight_count != '0);
        pop_bit  = fifo_q[rd_ptr_q];
        mis_nxt  = do_res && (pop_bit != resolve_taken);
        kill     = mis_nxt || flush;
        push     = accept && !kill;
        arch_nxt = do_res ? {arch_history[HISTORY_SIZE-2:0], resolve_taken} : arch_history;
    end

    always_comb begin
        spec_nxt  = spec_history;
        count_nxt = inflight_count;
        if (kill) begin
            spec_nxt  = arch_nxt;
            count_nxt = '0;
        end else begin
            if (push)
                spec_nxt = {spec_history[HISTORY_SIZE-2:0], pred_taken};
            case ({push, do_res})
                2'b10:   count_nxt = inflight_count + CW'(1);
                2'b01:   count_nxt = inflight_count - CW'(1);
                default: count_nxt = inflight_count;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_nxt;
    end

    // FSM: next state -- any kill (re)enters RECOVER for one cycle
    always_comb begin
        state_nxt = RUN;
        if (kill) state_nxt = RECOVER;
    end

    // FSM: outputs; pred_ready is registered from the next-cycle state and count
    always_comb begin
        recover_busy = (state_q == RECOVER);
        ready_nxt    = (state_nxt == RUN) && (count_nxt < CW'(CKPT_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q         <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            inflight_count <= '0;
            spec_history   <= '0;
            arch_history   <= '0;
            mispredict     <= 1'b0;
            underflow_err  <= 1'b0;
            pred_ready     <= 1'b0;
        end else begin
            spec_history   <= spec_nxt;
            arch_history   <= arch_nxt;
            inflight_count <= count_nxt;
            mispredict     <= mis_nxt;
            pred_ready     <= ready_nxt;
            if (resolve_valid && (inflight_count == '0))
                underflow_err <= 1'b1;
            if (kill) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr_q] <= pred_taken;
                    wr_ptr_q         <= wr_ptr_q + PW'(1);
                end
                if (do_res)
                    rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ghr_spec_ctrl.sv
// Self-checking bench for ghr_spec_ctrl: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_ghr_spec_ctrl;

    localparam int H = 64;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pred_valid = 1'b0, pred_taken = 1'b0;
    logic         resolve_valid = 1'b0, resolve_taken = 1'b0, flush = 1'b0;
    logic         pred_ready, mispredict, recover_busy, underflow_err;
    logic [H-1:0] spec_history, arch_history;
    logic [3:0]   inflight_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit           q[$];
    logic [H-1:0] m_spec, m_arch;
    logic         m_mis, m_uf, m_rec, m_ready;

    ghr_spec_ctrl #(.HISTORY_SIZE(H), .CKPT_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
        .spec_history(spec_history), .arch_history(arch_history),
        .mispredict(mispredict), .recover_busy(recover_busy),
        .inflight_count(inflight_count), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_spec = '0; m_arch = '0;
        m_mis = 0; m_uf = 0; m_rec = 0; m_ready = 0;
    endtask

    task automatic model_step(input logic pv, pt, rv, rt, fl);
        bit p;
        logic acc, mis;
        acc = pv && m_ready;
        mis = 0;
        if (rv && q.size() > 0) begin
            p = q.pop_front();
            mis = (p != rt);
            m_arch = {m_arch[H-2:0], rt};
        end else if (rv) begin
            m_uf = 1;
        end
        if (mis || fl) begin
            q.delete();
            m_spec = m_arch;
            m_rec = 1;
        end else begin
            m_rec = 0;
            if (acc) begin
                q.push_back(pt);
                m_spec = {m_spec[H-2:0], pt};
            end
        end
        m_mis = mis;
        m_ready = !m_rec && (q.size() < D);
    endtask

    task automatic drive(input logic pv, pt, rv, rt, fl);
        pred_valid = pv; pred_taken = pt;
        resolve_valid = rv; resolve_taken = rt; flush = fl;
        model_step(pv, pt, rv, rt, fl);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        pred_valid = 0; pred_taken = 0; resolve_valid = 0; resolve_taken = 0; flush = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #2;
        checks++;
        if ({spec_history, arch_history, inflight_count, mispredict, underflow_err,
             recover_busy, pred_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs spec=%h arch=%h cnt=%0d mis=%b uf=%b busy=%b rdy=%b exp all 0",
                     spec_history, arch_history, inflight_count, mispredict, underflow_err,
                     recover_busy, pred_ready);
        end
        do_reset();
        checks++;
        if (pred_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", pred_ready);
        end
    endtask

    task automatic test_predict();
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        checks++;
        if (spec_history !== 64'h5) begin errors++; $display("FAIL pred_spec got %h exp 5", spec_history); end
        checks++;
        if (inflight_count !== 4'd3) begin errors++; $display("FAIL pred_count got %0d exp 3", inflight_count); end
        checks++;
        if (arch_history !== 64'h0) begin errors++; $display("FAIL pred_arch got %h exp 0", arch_history); end
    endtask

    task automatic test_resolve();
        logic seen_mis;
        seen_mis = 0;
        drive(0, 0, 1, 1, 0); seen_mis |= mispredict;
        drive(0, 0, 1, 0, 0); seen_mis |= mispredict;
        drive(0, 0, 1, 1, 0); seen_mis |= mispredict;
        checks++;
        if (arch_history !== 64'h5) begin errors++; $display("FAIL res_arch got %h exp 5", arch_history); end
        checks++;
        if (inflight_count !== 4'd0) begin errors++; $display("FAIL res_count got %0d exp 0", inflight_count); end
        checks++;
        if (seen_mis !== 1'b0) begin errors++; $display("FAIL res_mispredict got %b exp 0", seen_mis); end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        checks++;
        if (mispredict !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", mispredict); end
        checks++;
        if (spec_history !== 64'h0 || arch_history !== 64'h0) begin
            errors++; $display("FAIL mis_hist spec=%h arch=%h exp 0/0", spec_history, arch_history);
        end
        checks++;
        if ({inflight_count, recover_busy, pred_ready} !== {4'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mis_recover cnt=%0d busy=%b rdy=%b exp 0 1 0",
                               inflight_count, recover_busy, pred_ready);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({mispredict, recover_busy, pred_ready} !== 3'b001) begin
            errors++; $display("FAIL mis_after mis=%b busy=%b rdy=%b exp 0 0 1",
                               mispredict, recover_busy, pred_ready);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < D; i++) drive(1, 1, 0, 0, 0);
        checks++;
        if ({inflight_count, pred_ready} !== {4'd8, 1'b0}) begin
            errors++; $display("FAIL full_state cnt=%0d rdy=%b exp 8 0", inflight_count, pred_ready);
        end
        drive(1, 0, 0, 0, 0);
        checks++;
        if (inflight_count !== 4'd8 || spec_history !== 64'hFF) begin
            errors++; $display("FAIL full_ignore cnt=%0d spec=%h exp 8 ff", inflight_count, spec_history);
        end
        drive(0, 0, 1, 1, 0);
        checks++;
        if ({inflight_count, pred_ready} !== {4'd7, 1'b1}) begin
            errors++; $display("FAIL full_pop cnt=%0d rdy=%b exp 7 1", inflight_count, pred_ready);
        end
        drive(1, 1, 1, 1, 0);
        checks++;
        if (inflight_count !== 4'd7 || spec_history !== 64'h1FF || mispredict !== 1'b0) begin
            errors++; $display("FAIL full_pushpop cnt=%0d spec=%h mis=%b exp 7 1ff 0",
                               inflight_count, spec_history, mispredict);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 1);
        checks++;
        if (arch_history !== 64'h1 || spec_history !== 64'h1) begin
            errors++; $display("FAIL flush_hist arch=%h spec=%h exp 1 1", arch_history, spec_history);
        end
        checks++;
        if ({inflight_count, mispredict, recover_busy, pred_ready} !== {4'd0, 3'b010}) begin
            errors++; $display("FAIL flush_state cnt=%0d mis=%b busy=%b rdy=%b exp 0 0 1 0",
                               inflight_count, mispredict, recover_busy, pred_ready);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({recover_busy, pred_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_after busy=%b rdy=%b exp 0 1", recover_busy, pred_ready);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 0, 1, 0, 0);
        checks++;
        if (underflow_err !== 1'b1 || arch_history !== 64'h0) begin
            errors++; $display("FAIL uf_set uf=%b arch=%h exp 1 0", underflow_err, arch_history);
        end
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        checks++;
        if (underflow_err !== 1'b1 || spec_history !== 64'h2) begin
            errors++; $display("FAIL uf_sticky uf=%b spec=%h exp 1 2", underflow_err, spec_history);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({spec_history, arch_history, inflight_count, mispredict, underflow_err,
             recover_busy, pred_ready} !== '0) begin
            errors++; $display("FAIL async_reset spec=%h arch=%h cnt=%0d uf=%b rdy=%b exp all 0",
                               spec_history, arch_history, inflight_count, underflow_err, pred_ready);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic pv, pt, rv, rt, fl;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            pv = ($urandom_range(0, 99) < 70);
            pt = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 99) < 45);
            if (q.size() > 0 && $urandom_range(0, 99) < 85) rt = q[0];
            else rt = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 99) < 3);
            drive(pv, pt, rv, rt, fl);
            checks++;
            if (spec_history !== m_spec) begin errors++; $display("FAIL rnd_spec cyc %0d got %h exp %h", i, spec_history, m_spec); end
            checks++;
            if (arch_history !== m_arch) begin errors++; $display("FAIL rnd_arch cyc %0d got %h exp %h", i, arch_history, m_arch); end
            checks++;
            if (inflight_count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, inflight_count, q.size()); end
            checks++;
            if (mispredict !== m_mis) begin errors++; $display("FAIL rnd_mis cyc %0d got %b exp %b", i, mispredict, m_mis); end
            checks++;
            if (recover_busy !== m_rec) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", i, recover_busy, m_rec); end
            checks++;
            if (pred_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, pred_ready, m_ready); end
            checks++;
            if (underflow_err !== m_uf) begin errors++; $display("FAIL rnd_uf cyc %0d got %b exp %b", i, underflow_err, m_uf); end
        end
    endtask

    initial begin
        test_reset();
        test_predict();
        test_resolve();
        test_mispredict();
        test_full();
        test_flush();
        test_underflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
